// File: rtl/prbs7_ber_monitor.sv
// BER measurement monitor for the PRBS7 checker: windowed accumulation of compared bits,
// errored bits, unlocked words and lock-loss events, with frozen results after done_o.
module prbs7_ber_monitor #(
  parameter int WIDTH     = 8,
  parameter int BIT_CNT_W = 48,
  parameter int ERR_CNT_W = 32,
  parameter int EVT_CNT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 clear_i,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic [31:0]          window_words_i,
  input  logic                 ena_i,
  input  logic                 lock_i,
  input  logic [WIDTH-1:0]     err_mask_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [BIT_CNT_W-1:0] bit_cnt_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o,
  output logic [EVT_CNT_W-1:0] unlock_words_o,
  output logic [EVT_CNT_W-1:0] lock_loss_o,
  output logic                 sat_o
);

  localparam int POP_W = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_LOCK, S_MEASURE, S_DRAIN, S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [31:0]            window_q, window_d;
  logic [31:0]            word_cnt_q, word_cnt_d;
  logic                   lock_prev_q, lock_prev_d;
  logic                   s1_valid_q, s1_valid_d;
  logic                   s1_lock_q, s1_lock_d;
  logic [POP_W-1:0]       s1_pop_q, s1_pop_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [EVT_CNT_W-1:0]   unlock_q, unlock_d;
  logic [EVT_CNT_W-1:0]   lock_loss_q, lock_loss_d;
  logic                   sat_q, sat_d;
  logic                   done_q, done_d;

  logic [POP_W-1:0]       pop;
  logic                   accept;
  logic                   last_word;
  logic [BIT_CNT_W:0]     bit_sum;
  logic [ERR_CNT_W:0]     err_sum;
  logic [EVT_CNT_W:0]     unlock_sum;
  logic [EVT_CNT_W:0]     lock_loss_sum;

  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + POP_W'(err_mask_i[i]);
    end
  end

  // One extra carry bit per sum; a set carry means the counter must clamp.
  assign bit_sum       = {1'b0, bit_cnt_q} + (BIT_CNT_W+1)'(WIDTH);
  assign err_sum       = {1'b0, err_cnt_q} + (ERR_CNT_W+1)'(s1_pop_q);
  assign unlock_sum    = {1'b0, unlock_q} + (EVT_CNT_W+1)'(1);
  assign lock_loss_sum = {1'b0, lock_loss_q} + (EVT_CNT_W+1)'(1);

  assign accept    = (state_q == S_MEASURE) && ena_i;
  assign last_word = accept && (window_q != 32'd0) && ((word_cnt_q + 32'd1) == window_q);

  always_comb begin
    state_d     = state_q;
    window_d    = window_q;
    word_cnt_d  = word_cnt_q;
    lock_prev_d = lock_i;
    s1_valid_d  = accept;
    s1_lock_d   = accept ? lock_i : s1_lock_q;
    s1_pop_d    = accept ? pop : s1_pop_q;
    bit_cnt_d   = bit_cnt_q;
    err_cnt_d   = err_cnt_q;
    unlock_d    = unlock_q;
    lock_loss_d = lock_loss_q;
    sat_d       = sat_q;
    done_d      = 1'b0;

    if (s1_valid_q) begin
      if (s1_lock_q) begin
        if (bit_sum[BIT_CNT_W]) begin
          bit_cnt_d = '1;
          sat_d     = 1'b1;
        end else begin
          bit_cnt_d = bit_sum[BIT_CNT_W-1:0];
        end
        if (err_sum[ERR_CNT_W]) begin
          err_cnt_d = '1;
          sat_d     = 1'b1;
        end else begin
          err_cnt_d = err_sum[ERR_CNT_W-1:0];
        end
      end else if (unlock_sum[EVT_CNT_W]) begin
        unlock_d = '1;
        sat_d    = 1'b1;
      end else begin
        unlock_d = unlock_sum[EVT_CNT_W-1:0];
      end
    end

    if ((state_q == S_MEASURE) && lock_prev_q && !lock_i) begin
      if (lock_loss_sum[EVT_CNT_W]) begin
        lock_loss_d = '1;
        sat_d       = 1'b1;
      end else begin
        lock_loss_d = lock_loss_sum[EVT_CNT_W-1:0];
      end
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        // Only IDLE/DONE can take a start, so no stage-2 update is pending here.
        if (start_i) begin
          state_d     = S_WAIT_LOCK;
          window_d    = window_words_i;
          word_cnt_d  = '0;
          bit_cnt_d   = '0;
          err_cnt_d   = '0;
          unlock_d    = '0;
          lock_loss_d = '0;
          sat_d       = 1'b0;
        end
      end
      S_WAIT_LOCK: begin
        if (stop_i)      state_d = S_DRAIN;
        else if (lock_i) state_d = S_MEASURE;
      end
      S_MEASURE: begin
        if (accept) word_cnt_d = word_cnt_q + 32'd1;
        if (stop_i || last_word) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i || clear_i) begin
      state_q     <= S_IDLE;
      window_q    <= '0;
      word_cnt_q  <= '0;
      lock_prev_q <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_lock_q   <= 1'b0;
      s1_pop_q    <= '0;
      bit_cnt_q   <= '0;
      err_cnt_q   <= '0;
      unlock_q    <= '0;
      lock_loss_q <= '0;
      sat_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      window_q    <= window_d;
      word_cnt_q  <= word_cnt_d;
      lock_prev_q <= lock_prev_d;
      s1_valid_q  <= s1_valid_d;
      s1_lock_q   <= s1_lock_d;
      s1_pop_q    <= s1_pop_d;
      bit_cnt_q   <= bit_cnt_d;
      err_cnt_q   <= err_cnt_d;
      unlock_q    <= unlock_d;
      lock_loss_q <= lock_loss_d;
      sat_q       <= sat_d;
      done_q      <= done_d;
    end
  end

  assign busy_o         = (state_q == S_WAIT_LOCK) || (state_q == S_MEASURE) || (state_q == S_DRAIN);
  assign done_o         = done_q;
  assign bit_cnt_o      = bit_cnt_q;
  assign err_cnt_o      = err_cnt_q;
  assign unlock_words_o = unlock_q;
  assign lock_loss_o    = lock_loss_q;
  assign sat_o          = sat_q;

endmodule
